// File: rtl/counter_arbiter.sv
// -----------------------------------------------------------------------------
// counter_arbiter
//
// Round-robin scheduler sharing one WIDTH-bit interval counter between
// NUM_REQ requesters. The granted requester runs the counter from 0 up to
// its duration (sampled at grant), then receives a one-cycle done pulse.
// Dropping the request while running aborts the job without a done pulse.
//
// Ports:
//   clock  - rising-edge clock
//   rst    - asynchronous active-low reset
//   req    - per-requester request level, held high until done
//   dur    - per-requester duration, lane i at dur[i*WIDTH +: WIDTH]
//   gnt    - one-hot grant (registered)
//   done   - one-hot completion pulse, one cycle (registered)
//   busy   - high whenever the scheduler is not idle
//   d_en   - counter enable, high while the interval is running
//   d_out  - current counter value
// -----------------------------------------------------------------------------
module counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 12
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   dur,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic                       d_en,
    output logic [WIDTH-1:0]           d_out
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0]      LAST_INIT = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IW:0]        NUM_EXT   = (IW+1)'(NUM_REQ);

    logic [1:0]         state_r;
    logic [IW-1:0]      w_r;
    logic [IW-1:0]      last_r;
    logic [WIDTH-1:0]   target_r;
    logic [WIDTH-1:0]   count_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] done_r;

    logic [IW-1:0]      win_s;
    logic               win_valid_s;

    // Round-robin pick: scan offsets from the far end down to last+1 so the
    // requester nearest after the last grant overwrites any earlier candidate.
    always_comb begin
        logic [IW:0] cand;
        win_s       = last_r;
        win_valid_s = 1'b0;
        cand        = {(IW+1){1'b0}};
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand        = {1'b0, last_r} + (IW+1)'(i);
            cand        = (cand >= NUM_EXT) ? (cand - NUM_EXT) : cand;
            win_s       = req[cand[IW-1:0]] ? cand[IW-1:0] : win_s;
            win_valid_s = req[cand[IW-1:0]] | win_valid_s;
        end
    end

    // Scheduler state, interval counter and registered grant/done outputs.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_r  <= S_IDLE;
            w_r      <= {IW{1'b0}};
            last_r   <= LAST_INIT;
            target_r <= {WIDTH{1'b0}};
            count_r  <= {WIDTH{1'b0}};
            gnt_r    <= {NUM_REQ{1'b0}};
            done_r   <= {NUM_REQ{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (win_valid_s) begin
                        state_r  <= S_RUN;
                        w_r      <= win_s;
                        gnt_r    <= ONE_HOT0 << win_s;
                        target_r <= dur[win_s*WIDTH +: WIDTH];
                        count_r  <= {WIDTH{1'b0}};
                    end
                end
                S_RUN: begin
                    // Abort outranks terminal count; count holds either way.
                    if (!req[w_r]) begin
                        state_r <= S_IDLE;
                        gnt_r   <= {NUM_REQ{1'b0}};
                        last_r  <= w_r;
                    end else if (count_r == target_r) begin
                        state_r <= S_DONE;
                        done_r  <= ONE_HOT0 << w_r;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    gnt_r   <= {NUM_REQ{1'b0}};
                    done_r  <= {NUM_REQ{1'b0}};
                    last_r  <= w_r;
                end
                default: begin
                    state_r <= S_IDLE;
                    gnt_r   <= {NUM_REQ{1'b0}};
                    done_r  <= {NUM_REQ{1'b0}};
                end
            endcase
        end
    end

    assign gnt   = gnt_r;
    assign done  = done_r;
    assign d_out = count_r;
    assign d_en  = (state_r == S_RUN);
    assign busy  = (state_r != S_IDLE);

endmodule

// File: tb/tb_counter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_arbiter
//
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a job-level model: the model tracks which requester owns the
// counter and how many edges have passed since its grant, and derives the
// expected outputs from that age and the duration sampled at grant.
// -----------------------------------------------------------------------------
module tb_counter_arbiter;

    localparam int NR = 4;
    localparam int W  = 12;

    logic              clock = 1'b0;
    logic              rst   = 1'b0;
    logic [NR-1:0]     req_v = '0;
    logic [NR*W-1:0]   dur_v = '0;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic              busy;
    logic              d_en;
    logic [W-1:0]      d_out;

    int checks   = 0;
    int failures = 0;

    // model: owner (-1 = idle), edges since grant, sampled duration,
    // last served requester, value d_out holds while idle
    int m_owner;
    int m_age;
    int m_d;
    int m_last;
    int m_hold;

    counter_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clock (clock),
        .rst   (rst),
        .req   (req_v),
        .dur   (dur_v),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .d_en  (d_en),
        .d_out (d_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_age   = 0;
        m_d     = 0;
        m_last  = NR - 1;
        m_hold  = 0;
    endfunction

    // One clock edge of the job-level model, using the inputs held before it.
    function automatic void model_edge();
        bit found;
        int c;
        found = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
                c = (m_last + k) % NR;
                if (!found && req_v[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_age   = 0;
                    m_d     = int'(dur_v[c*W +: W]);
                end
            end
        end else if (m_age == m_d + 1) begin
            m_last  = m_owner;
            m_hold  = m_d;
            m_owner = -1;
        end else if (!req_v[m_owner]) begin
            m_last  = m_owner;
            m_hold  = m_age;
            m_owner = -1;
        end else begin
            m_age++;
        end
    endfunction

    task automatic check_outputs();
        logic [NR-1:0] eg;
        logic [NR-1:0] ed;
        logic          ebz;
        logic          een;
        int            edo;
        eg  = '0;
        ed  = '0;
        ebz = 1'b0;
        een = 1'b0;
        edo = m_hold;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ebz = 1'b1;
            if (m_age <= m_d) begin
                een = 1'b1;
                edo = m_age;
            end else begin
                ed[m_owner] = 1'b1;
                edo = m_d;
            end
        end
        chk("gnt",   32'(gnt),   32'(eg));
        chk("done",  32'(done),  32'(ed));
        chk("busy",  32'(busy),  32'(ebz));
        chk("d_en",  32'(d_en),  32'(een));
        chk("d_out", 32'(d_out), 32'(edo));
    endtask

    task automatic tick();
        @(posedge clock);
        if (rst) model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req_v = '0;
        @(posedge clock);
        #1;
        model_reset();
        check_outputs();
        rst = 1'b1;
    endtask

    task automatic set_dur(input int i, input int val);
        dur_v[i*W +: W] = W'(val);
    endtask

    function automatic int oh_index(input logic [NR-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        int order[$];
        int gcyc[$];
        logic [NR-1:0] prev_g;
        int cyc;
        int en_cnt;
        int max_out;
        bit hit;

        model_reset();

        // single requester, dur=5
        do_reset();
        set_dur(0, 5);
        req_v = 4'b0001;
        repeat (10) tick();
        req_v = '0;
        repeat (2) tick();

        // all requesting, dur=2: rotation and spacing
        do_reset();
        for (int i = 0; i < NR; i++) set_dur(i, 2);
        req_v  = 4'b1111;
        prev_g = '0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (gnt != '0 && gnt != prev_g) begin
                order.push_back(oh_index(gnt));
                gcyc.push_back(c);
            end
            prev_g = gnt;
        end
        chk("grant_count_ge5", 32'(order.size() >= 5), 32'd1);
        if (order.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("grant_order", 32'(order[k]), 32'(k % NR));
            for (int k = 1; k < 5; k++) chk("grant_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd5);
        end
        req_v = '0;
        repeat (4) tick();

        // dur=0 on requester 2 alone
        do_reset();
        set_dur(2, 0);
        req_v = 4'b0100;
        repeat (3) tick();
        req_v = '0;
        repeat (2) tick();

        // abort requester 1 at d_out=40, pending 3 beats 0
        do_reset();
        set_dur(1, 100);
        set_dur(0, 3);
        set_dur(3, 3);
        req_v = 4'b0010;
        tick();
        req_v = 4'b1011;
        hit = 1'b0;
        for (int c = 0; c < 150 && !hit; c++) begin
            tick();
            if (d_out == 12'd40) hit = 1'b1;
        end
        chk("wait_dout40", 32'(hit), 32'd1);
        req_v = 4'b1001;
        tick();
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_dout", 32'(d_out), 32'd40);
        tick();
        chk("after_abort_gnt", 32'(gnt), 32'h8);
        repeat (14) tick();
        req_v = '0;
        repeat (6) tick();

        // max duration, dur changed mid-run
        do_reset();
        set_dur(0, 4095);
        req_v = 4'b0001;
        tick();
        en_cnt  = d_en ? 1 : 0;
        max_out = int'(d_out);
        hit     = 1'b0;
        for (int c = 0; c < 4200 && !hit; c++) begin
            if (c == 10) set_dur(0, 3);
            tick();
            if (d_en) en_cnt++;
            if (int'(d_out) > max_out) max_out = int'(d_out);
            if (done != '0) hit = 1'b1;
        end
        chk("long_done_seen", 32'(hit), 32'd1);
        chk("long_run_cycles", 32'(en_cnt), 32'd4096);
        chk("long_max_dout", 32'(max_out), 32'hFFF);
        req_v = '0;
        repeat (3) tick();

        // asynchronous reset mid-run at d_out=0x123
        do_reset();
        set_dur(0, 12'h200);
        req_v = 4'b0001;
        hit = 1'b0;
        for (int c = 0; c < 400 && !hit; c++) begin
            tick();
            if (d_out == 12'h123) hit = 1'b1;
        end
        chk("wait_dout123", 32'(hit), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clock);
        #1;
        for (int i = 0; i < NR; i++) set_dur(i, 1);
        req_v = 4'b1111;
        rst   = 1'b1;
        tick();
        chk("post_reset_first_gnt", 32'(gnt), 32'h1);
        repeat (10) tick();

        // randomized traffic
        do_reset();
        for (cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (m_owner == i && m_age <= m_d) begin
                    if ($urandom_range(0, 63) == 0) req_v[i] = 1'b0;
                end else if (m_owner == i) begin
                    if ($urandom_range(0, 1) == 0) req_v[i] = 1'b0;
                end else if (!req_v[i]) begin
                    if ($urandom_range(0, 3) == 0) req_v[i] = 1'b1;
                end
                set_dur(i, int'($urandom_range(0, 6)));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin scheduler that shares one 12-bit interval counter between up to NUM_REQ requesters. Each granted requester runs the counter for its own programmed duration, then receives a one-cycle completion pulse. The block owns the counter register and exposes its value and enable, so it drops in wherever the standalone counter served a single client.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 12: counter and duration width.

- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  NUM_REQ  per-requester request level; hold high until done.
- dur  in  NUM_REQ*WIDTH  duration for requester i at dur[i*WIDTH +: WIDTH]; sampled at grant.
- gnt  out  NUM_REQ  one-hot grant, registered.
- done  out  NUM_REQ  one-hot completion pulse, one cycle, registered.
- busy  out  1  high whenever state is not IDLE.
- d_en  out  1  counter enable, high exactly in RUN.
- d_out  out  WIDTH  current counter value.

## Operation
- States: IDLE, RUN, DONE. Internal registers: w (granted index), target[WIDTH], count[WIDTH], last (index of last grant).
- Reset: state IDLE, gnt=0, done=0, count=0, target=0, last=NUM_REQ-1. Requester 0 therefore wins the first arbitration.
- IDLE, any req high: w is the first set req bit scanning (last+1) mod NUM_REQ upward with wrap. Next state RUN. gnt<=onehot(w), target<=dur[w], count<=0.
- IDLE, no req: hold. count holds its last value.
- RUN, req[w] low: abort. Next state IDLE, gnt<=0, no done pulse, last<=w, count holds.
- RUN, req[w] high, count==target: next state DONE, done<=onehot(w), count holds.
- RUN, otherwise: count<=count+1.
- DONE: next state IDLE unconditionally. gnt<=0, done<=0, last<=w.
- The abort check has priority over the terminal-count check in the same cycle.
- dur is sampled only at grant. Later changes to dur have no effect on the running interval.
- count never exceeds target, so no wrap is possible. dur=4095 yields 4096 RUN cycles.
- Requests arriving while busy wait, and are arbitrated in IDLE after the current job.
- A requester still holding req after its done competes again, with lowest priority.
- d_out = count, d_en = (state==RUN), busy = (state!=IDLE). All are decoded from registers, with no combinational path from req.
- Reset asserted mid-RUN forces all outputs to their reset values immediately. No done pulse is issued.

## Timing
- Edge E0 samples req in IDLE. After E0: gnt high, d_en high, d_out=0.
- After edge Ek (k ≤ D, where D = sampled dur): d_out = k.
- At edge E(D+1): terminal count is detected. done is high for the cycle after E(D+1); gnt stays high during that cycle and d_en is low.
- After E(D+2): IDLE, gnt=0.
- Earliest next grant: after E(D+3).
- Grant-to-done latency: D+1 cycles. Occupancy per job: D+3 cycles.
- Abort latency: one edge after req[w] falls, gnt is 0 and the state is IDLE.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1,0,…

## Test plan
- Reset, then req=4'b0001, dur0=5: gnt=0001 one cycle later, d_out steps 0..5, done=0001 for one cycle 6 cycles after grant, gnt=0 next cycle.
- req=4'b1111, all dur=2: grant order 0,1,2,3,0. Each done is a single-cycle pulse; grant-to-grant spacing is 5 cycles.
- dur=0 on requester 2, requester alone: done=0100 one cycle after grant, d_out stays 0.
- Requester 1 dur=100; drop req1 at d_out=40: gnt=0 next cycle, no done, d_out holds 40. A pending req3 is granted next, before req0.
- dur=4095 on requester 0: d_out reaches 0xFFF with no wrap, done after 4096 RUN cycles. Changing dur0 mid-run does not alter completion.
- Pull rst low mid-RUN at d_out=0x123: gnt, done, busy, d_en and d_out go to 0 asynchronously. After release, requester 0 has first priority.
